// File: rtl/execute_unit_pkg.sv
// Shared types and defaults for the execute stage.
package execute_unit_pkg;

  localparam int unsigned DWIDTH_DEF = 16;
  localparam int unsigned AWIDTH_DEF = 12;

  // The position in this list is the priority position: a lower value wins.
  typedef enum logic [3:0] {
    OP_ADD,
    OP_LOAD,
    OP_STORE,
    OP_BRANCH,
    OP_ISZ,
    OP_CLR_AC,
    OP_CLR_E,
    OP_COMP_AC,
    OP_LOAD_AC,
    OP_CIR_R,
    OP_CIR_L,
    OP_INC_AC
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_e;

  // Bit 0 of strobes is the highest-priority operation (OP_ADD).
  function automatic op_e pick_op(input logic [11:0] strobes);
    logic found;
    pick_op = OP_ADD;
    found   = 1'b0;
    for (int unsigned i = 0; i < 12; i++) begin
      if (strobes[i] && !found) begin
        pick_op = op_e'(4'(i));
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/execute_unit_ac_alu.sv
// Combinational accumulator / extend-bit arithmetic.
module ac_alu
  import execute_unit_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF
) (
  input  op_e               op,
  input  logic [DWIDTH-1:0] ac,
  input  logic              e,
  input  logic [DWIDTH-1:0] m,
  input  logic [7:0]        imm,
  output logic [DWIDTH-1:0] ac_nxt,
  output logic              e_nxt,
  output logic [DWIDTH-1:0] isz_val,
  output logic              isz_zero
);

  logic [DWIDTH:0] sum;

  // Next AC/E for every operation; untouched operations pass AC/E through.
  always_comb begin
    ac_nxt = ac;
    e_nxt  = e;
    sum    = {1'b0, ac} + {1'b0, m};
    case (op)
      OP_ADD:     {e_nxt, ac_nxt} = sum;
      OP_LOAD:    ac_nxt = m;
      OP_CLR_AC:  ac_nxt = '0;
      OP_CLR_E:   e_nxt = 1'b0;
      OP_COMP_AC: ac_nxt = ~ac;
      OP_LOAD_AC: ac_nxt = DWIDTH'(imm);
      OP_CIR_R:   {ac_nxt, e_nxt} = {e, ac};
      OP_CIR_L:   {e_nxt, ac_nxt} = {ac, e};
      OP_INC_AC:  ac_nxt = ac + DWIDTH'(1);
      default:    ;
    endcase
  end

  assign isz_val  = m + DWIDTH'(1);
  assign isz_zero = (isz_val == '0);

endmodule

// File: rtl/execute_unit.sv
// Execute stage: owns AC, E and PC and sequences memory-reference operations.
module execute_unit
  import execute_unit_pkg::*;
#(
  parameter int unsigned DWIDTH = DWIDTH_DEF,
  parameter int unsigned AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_execute,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic              i_clr_ac,
  input  logic              i_clr_e,
  input  logic              i_comp_ac,
  input  logic              i_load_ac,
  input  logic              i_cir_r,
  input  logic              i_cir_l,
  input  logic              i_inc_ac,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic [7:0]        i_imm,
  input  logic              i_pc_inc,
  input  logic [DWIDTH-1:0] i_mem_rdata,
  output logic [AWIDTH-1:0] o_mem_addr,
  output logic              o_mem_ce,
  output logic              o_mem_we,
  output logic [DWIDTH-1:0] o_mem_wdata,
  output logic [DWIDTH-1:0] o_ac,
  output logic              o_e,
  output logic [AWIDTH-1:0] o_pc,
  output logic              o_busy,
  output logic              o_ex_done
);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              armed_q, armed_d;
  logic [DWIDTH-1:0] ac_q, ac_d;
  logic              e_q, e_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic [DWIDTH-1:0] mem_wdata_q, mem_wdata_d;

  logic [11:0]       strobes;
  op_e               op_now;
  op_e               alu_op;
  logic [DWIDTH-1:0] alu_ac;
  logic              alu_e;
  logic [DWIDTH-1:0] alu_isz;
  logic              alu_zero;

  assign strobes = {i_inc_ac, i_cir_l, i_cir_r, i_load_ac, i_comp_ac, i_clr_e,
                    i_clr_ac, i_isz, i_branch, i_store, i_load, i_add};

  // Register-reference ops resolve from the live strobes at accept; memory
  // ops resolve from the latched op at CAPTURE.
  always_comb begin
    op_now = pick_op(strobes);
    alu_op = (state_q == S_IDLE) ? op_now : op_q;
  end

  ac_alu #(.DWIDTH(DWIDTH)) u_alu (
    .op       (alu_op),
    .ac       (ac_q),
    .e        (e_q),
    .m        (i_mem_rdata),
    .imm      (i_imm),
    .ac_nxt   (alu_ac),
    .e_nxt    (alu_e),
    .isz_val  (alu_isz),
    .isz_zero (alu_zero)
  );

  // Sequencer: next state, register updates and registered memory controls.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    armed_d     = armed_q | ~i_execute;
    ac_d        = ac_q;
    e_d         = e_q;
    pc_d        = i_pc_inc ? pc_q + AWIDTH'(1) : pc_q;
    mem_addr_d  = mem_addr_q;
    mem_ce_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_execute && armed_q) begin
          armed_d    = 1'b0;
          mem_addr_d = i_addr;
          state_d    = S_DONE;
          if (|strobes) begin
            op_d = op_now;
            case (op_now)
              OP_ADD, OP_LOAD, OP_ISZ: begin
                state_d  = S_READ;
                mem_ce_d = 1'b1;
              end
              OP_STORE: begin
                state_d     = S_WRITE;
                mem_ce_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_wdata_d = ac_q;
              end
              OP_BRANCH: pc_d = i_addr;
              default: begin
                ac_d = alu_ac;
                e_d  = alu_e;
              end
            endcase
          end
        end
      end
      S_READ: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (op_q == OP_ISZ) begin
          state_d     = S_WRITE;
          mem_ce_d    = 1'b1;
          mem_we_d    = 1'b1;
          mem_wdata_d = alu_isz;
          if (alu_zero) begin
            pc_d = pc_q + AWIDTH'(1);
          end
        end else begin
          state_d = S_DONE;
          ac_d    = alu_ac;
          e_d     = alu_e;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_ADD;
      armed_q     <= 1'b1;
      ac_q        <= '0;
      e_q         <= 1'b0;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_ce_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      armed_q     <= armed_d;
      ac_q        <= ac_d;
      e_q         <= e_d;
      pc_q        <= pc_d;
      mem_addr_q  <= mem_addr_d;
      mem_ce_q    <= mem_ce_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_ce    = mem_ce_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_ac        = ac_q;
  assign o_e         = e_q;
  assign o_pc        = pc_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_ex_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_execute_unit.sv
// Directed and randomized checks of execute_unit against a behavioural model.
module tb_execute_unit;

  localparam logic [11:0] M_ADD     = 12'h001;
  localparam logic [11:0] M_LOAD    = 12'h002;
  localparam logic [11:0] M_STORE   = 12'h004;
  localparam logic [11:0] M_BRANCH  = 12'h008;
  localparam logic [11:0] M_ISZ     = 12'h010;
  localparam logic [11:0] M_CLR_AC  = 12'h020;
  localparam logic [11:0] M_CLR_E   = 12'h040;
  localparam logic [11:0] M_LOAD_AC = 12'h100;
  localparam logic [11:0] M_CIR_R   = 12'h200;
  localparam logic [11:0] M_CIR_L   = 12'h400;
  localparam logic [11:0] M_INC     = 12'h800;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_execute;
  logic [11:0] strb;
  logic [11:0] i_addr;
  logic [7:0]  i_imm;
  logic        i_pc_inc;
  logic [15:0] mem_rdata;
  logic [11:0] o_mem_addr;
  logic        o_mem_ce, o_mem_we;
  logic [15:0] o_mem_wdata;
  logic [15:0] o_ac;
  logic        o_e;
  logic [11:0] o_pc;
  logic        o_busy, o_ex_done;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  // Behavioural model state.
  logic [15:0] m_ac;
  logic        m_e;
  logic [11:0] m_pc;

  // Synchronous single-port memory with a backdoor preload port.
  logic [15:0] mem [0:4095];
  logic        pk_en;
  logic [11:0] pk_addr;
  logic [15:0] pk_data;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pk_en) mem[pk_addr] <= pk_data;
    else if (o_mem_ce) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      else          mem_rdata <= mem[o_mem_addr];
    end
  end

  execute_unit #(.DWIDTH(16), .AWIDTH(12)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_execute   (i_execute),
    .i_add       (strb[0]),
    .i_load      (strb[1]),
    .i_store     (strb[2]),
    .i_branch    (strb[3]),
    .i_isz       (strb[4]),
    .i_clr_ac    (strb[5]),
    .i_clr_e     (strb[6]),
    .i_comp_ac   (strb[7]),
    .i_load_ac   (strb[8]),
    .i_cir_r     (strb[9]),
    .i_cir_l     (strb[10]),
    .i_inc_ac    (strb[11]),
    .i_addr      (i_addr),
    .i_imm       (i_imm),
    .i_pc_inc    (i_pc_inc),
    .i_mem_rdata (mem_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_ce    (o_mem_ce),
    .o_mem_we    (o_mem_we),
    .o_mem_wdata (o_mem_wdata),
    .o_ac        (o_ac),
    .o_e         (o_e),
    .o_pc        (o_pc),
    .o_busy      (o_busy),
    .o_ex_done   (o_ex_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ac"}, 32'(o_ac), 32'(m_ac));
    chk({tag, ".e"},  32'(o_e),  32'(m_e));
    chk({tag, ".pc"}, 32'(o_pc), 32'(m_pc));
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    @(negedge clk);
    pk_en = 1'b1; pk_addr = a; pk_data = d;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  // One full operation: model update, drive, observe memory traffic, check.
  task automatic do_op(input string tag, input logic [11:0] mask, input logic [11:0] a,
                       input logic [7:0] im, input logic [15:0] mval, input logic pcinc);
    int unsigned k, lat, exp_rd, exp_wr, s;
    int unsigned done_cyc, rd, wr, raddr_bad;
    logic [15:0] wr_exp, wd;
    logic [11:0] wa;
    logic        ne;
    k = 12;
    for (int i = 0; i < 12; i++) if (mask[i] && k == 12) k = i;
    lat = 1; exp_rd = 0; exp_wr = 0; wr_exp = '0;
    if (k == 0 || k == 1 || k == 4) poke(a, mval);
    if (pcinc) m_pc = m_pc + 12'd1;
    case (k)
      0: begin s = 32'(m_ac) + 32'(mval); m_ac = 16'(s); m_e = (s > 32'hFFFF); lat = 3; exp_rd = 1; end
      1: begin m_ac = mval; lat = 3; exp_rd = 1; end
      2: begin wr_exp = m_ac; lat = 2; exp_wr = 1; end
      3: m_pc = a;
      4: begin
        wr_exp = mval + 16'd1; lat = 4; exp_rd = 1; exp_wr = 1;
        if (wr_exp == 16'd0) m_pc = m_pc + 12'd1;
      end
      5: m_ac = 16'd0;
      6: m_e = 1'b0;
      7: m_ac = ~m_ac;
      8: m_ac = {8'h00, im};
      9: begin ne = m_ac[0]; m_ac = (m_ac >> 1) | (m_e ? 16'h8000 : 16'h0000); m_e = ne; end
      10: begin ne = m_ac[15]; m_ac = (m_ac << 1) | {15'd0, m_e}; m_e = ne; end
      11: m_ac = m_ac + 16'd1;
      default: ;
    endcase

    @(negedge clk);
    strb = mask; i_addr = a; i_imm = im; i_pc_inc = pcinc; i_execute = 1'b1;
    @(posedge clk);
    done_cyc = 0; rd = 0; wr = 0; raddr_bad = 0; wd = '0; wa = '0;
    for (int c = 1; c <= 8 && done_cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin strb = '0; i_pc_inc = 1'b0; end
      if (o_mem_ce && !o_mem_we) begin rd++; if (o_mem_addr !== a) raddr_bad++; end
      if (o_mem_ce && o_mem_we) begin wr++; wd = o_mem_wdata; wa = o_mem_addr; end
      if (o_ex_done) done_cyc = c;
    end
    i_execute = 1'b0;
    chk({tag, ".latency"}, done_cyc, lat);
    @(negedge clk);
    chk({tag, ".done_width"}, 32'(o_ex_done), 0);
    chk({tag, ".reads"}, rd, exp_rd);
    chk({tag, ".writes"}, wr, exp_wr);
    chk({tag, ".raddr"}, raddr_bad, 0);
    if (exp_wr != 0) begin
      chk({tag, ".waddr"}, 32'(wa), 32'(a));
      chk({tag, ".wdata"}, 32'(wd), 32'(wr_exp));
      chk({tag, ".mem"}, 32'(mem[a]), 32'(wr_exp));
    end
    check_regs(tag);
  endtask

  initial begin : main
    logic [11:0] mask;
    int unsigned ndone;
    reset_n = 1'b0; i_execute = 1'b0; strb = '0; i_addr = '0; i_imm = '0;
    i_pc_inc = 1'b0; pk_en = 1'b0; pk_addr = '0; pk_data = '0; mem_rdata = '0;
    m_ac = '0; m_e = 1'b0; m_pc = '0;
    repeat (2) @(negedge clk);
    check_regs("reset");
    chk("reset.ce", 32'(o_mem_ce), 0);
    chk("reset.we", 32'(o_mem_we), 0);
    chk("reset.addr", 32'(o_mem_addr), 0);
    chk("reset.wdata", 32'(o_mem_wdata), 0);
    chk("reset.busy", 32'(o_busy), 0);
    chk("reset.done", 32'(o_ex_done), 0);
    reset_n = 1'b1;

    do_op("load_ac", M_LOAD_AC, 12'h000, 8'h5A, 16'h0, 1'b0);
    do_op("load_ac1", M_LOAD_AC, 12'h000, 8'h01, 16'h0, 1'b0);
    do_op("add_carry", M_ADD, 12'h010, 8'h00, 16'hFFFF, 1'b0);
    do_op("branch", M_BRANCH, 12'h100, 8'h00, 16'h0, 1'b0);
    do_op("isz_skip", M_ISZ, 12'h020, 8'h00, 16'hFFFF, 1'b0);
    do_op("isz_noskip", M_ISZ, 12'h020, 8'h00, 16'h0005, 1'b0);
    do_op("load_8001", M_LOAD, 12'h030, 8'h00, 16'h8001, 1'b0);
    do_op("clr_e", M_CLR_E, 12'h000, 8'h00, 16'h0, 1'b0);
    do_op("cir_r", M_CIR_R, 12'h000, 8'h00, 16'h0, 1'b0);
    do_op("cir_l", M_CIR_L, 12'h000, 8'h00, 16'h0, 1'b0);
    do_op("store", M_STORE, 12'h040, 8'h00, 16'h0, 1'b0);
    do_op("prio_clr_inc", M_CLR_AC | M_INC, 12'h000, 8'h00, 16'h0, 1'b0);
    do_op("prio_store_isz", M_STORE | M_ISZ, 12'h041, 8'h00, 16'h0, 1'b0);
    do_op("no_strobe", 12'h000, 12'h000, 8'h00, 16'h0, 1'b0);
    do_op("branch_pcinc", M_BRANCH, 12'hFFF, 8'h00, 16'h0, 1'b1);

    // PC wraps on a plain fetch increment.
    @(negedge clk); i_pc_inc = 1'b1;
    @(negedge clk); i_pc_inc = 1'b0; m_pc = m_pc + 12'd1;
    chk("pc_wrap", 32'(o_pc), 32'(m_pc));

    // Held i_execute executes once; a one-cycle drop re-arms.
    do_op("load_ac77", M_LOAD_AC, 12'h000, 8'h77, 16'h0, 1'b0);
    @(negedge clk); strb = M_CLR_AC; i_execute = 1'b1; ndone = 0;
    repeat (7) begin @(negedge clk); if (o_ex_done) ndone++; end
    m_ac = '0;
    chk("hold_once", ndone, 1);
    chk("hold.ac", 32'(o_ac), 32'(m_ac));
    i_execute = 1'b0;
    @(negedge clk); i_execute = 1'b1; ndone = 0;
    repeat (4) begin @(negedge clk); if (o_ex_done) ndone++; end
    chk("reexec", ndone, 1);
    i_execute = 1'b0; strb = '0;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 7)      mask = 12'(1) << $urandom_range(0, 11);
      else if (r < 9) mask = (12'(1) << $urandom_range(0, 11)) | (12'(1) << $urandom_range(0, 11));
      else            mask = '0;
      do_op("rand", mask, 12'($urandom), 8'($urandom), 16'($urandom), 1'($urandom));
    end

    // Reset during the isz WRITE cycle aborts the write.
    do_op("pre_rst_ld", M_LOAD_AC, 12'h000, 8'hC3, 16'h0, 1'b0);
    do_op("pre_rst_br", M_BRANCH, 12'h321, 8'h00, 16'h0, 1'b0);
    poke(12'h055, 16'h1234);
    @(negedge clk); strb = M_ISZ; i_addr = 12'h055; i_execute = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6 && !(o_mem_ce && o_mem_we); c++) begin
      @(negedge clk);
      strb = '0;
    end
    chk("rst.reached_write", 32'(o_mem_we), 1);
    reset_n = 1'b0;
    #1;
    m_ac = '0; m_e = 1'b0; m_pc = '0;
    chk("rst.ce", 32'(o_mem_ce), 0);
    chk("rst.we", 32'(o_mem_we), 0);
    chk("rst.busy", 32'(o_busy), 0);
    chk("rst.done", 32'(o_ex_done), 0);
    check_regs("rst");
    i_execute = 1'b0;
    @(negedge clk);
    chk("rst.mem_kept", 32'(mem[12'h055]), 32'h1234);
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (o_ex_done) ndone++; end
    chk("rst.no_done", ndone, 0);
    do_op("post_rst", M_INC, 12'h000, 8'h00, 16'h0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
